// File: rtl/pc_conf_pkg.sv
// Shared types and default sizing for the PC config-word assembler.
package pc_conf_pkg;

  localparam int DEF_NCONF   = 16;
  localparam int DEF_NCHAN   = 2;
  localparam int DEF_NWORDS  = 3;
  localparam int DEF_TIMEOUT = 256;

  typedef logic [DEF_NCONF-1:0] conf_word_t;
  typedef logic [$clog2(DEF_NCHAN+1)-1:0] lane_count_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    LAST = 1'b1
  } lane_state_e;

  // Count at which one more accepted word moves a lane into LAST.
  function automatic int last_fill_count(input int nwords);
    return nwords - 2;
  endfunction

endpackage

// File: rtl/pc_conf_assembler_lane.sv
// One assembler lane: packs NWORDS config words into a double-buffered program word.
// PC_CONF_ASSEMBLER_TIMEOUT_EN adds an idle timeout that discards partial assemblies.
module pc_conf_assembler_lane
  import pc_conf_pkg::*;
#(
  parameter int NCONF   = DEF_NCONF,
  parameter int NWORDS  = DEF_NWORDS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCONF-1:0]          conf_in_d,
  input  logic                      conf_in_v,
  output logic                      conf_in_a,
  output logic [NCONF*NWORDS-1:0]   prog_out_d,
  output logic                      prog_out_v,
  input  logic                      prog_out_a,
  output logic [$clog2(NWORDS)-1:0] words_pending,
  input  logic                      flush,
  output logic                      err_timeout
);

  localparam int CW = $clog2(NWORDS);
  localparam int HW = NCONF * (NWORDS - 1);
  localparam int PW = NCONF * NWORDS;

  lane_state_e     state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [HW-1:0]   hold_r, hold_s;
  logic [PW-1:0]   out_d_r, out_d_s;
  logic            out_v_r, out_v_s;
  logic            err_r, err_s;
  logic            stall_s;
  logic            hs_s;
  logic            timeout_s;

  // The final word is refused only when the completed packet has nowhere to go.
  assign stall_s   = (state_r == LAST) && out_v_r && !prog_out_a;
  assign conf_in_a = conf_in_v && !flush && !stall_s;
  assign hs_s      = conf_in_a;

  assign prog_out_d    = out_d_r;
  assign prog_out_v    = out_v_r;
  assign words_pending = cnt_r;
  assign err_timeout   = err_r;

`ifdef PC_CONF_ASSEMBLER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_r, idle_s;

  // Idle counter: runs only while partial data is held and no word arrives.
  always_comb begin
    idle_s    = idle_r;
    timeout_s = 1'b0;
    if (flush || hs_s || (cnt_r == {CW{1'b0}})) begin
      idle_s = {IW{1'b0}};
    end else if (idle_r == IW'(TIMEOUT - 1)) begin
      idle_s    = {IW{1'b0}};
      timeout_s = 1'b1;
    end else begin
      idle_s = idle_r + IW'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_r <= {IW{1'b0}};
    end else begin
      idle_r <= idle_s;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Lane next-state: flush beats a handshake, a handshake beats timeout.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    hold_s  = hold_r;
    out_d_s = out_d_r;
    err_s   = err_r;
    if (out_v_r && prog_out_a) begin
      out_v_s = 1'b0;
    end else begin
      out_v_s = out_v_r;
    end
    if (flush) begin
      state_s = FILL;
      cnt_s   = {CW{1'b0}};
    end else if (hs_s) begin
      case (state_r)
        LAST: begin
          state_s = FILL;
          cnt_s   = {CW{1'b0}};
          out_d_s = {hold_r, conf_in_d};
          out_v_s = 1'b1;
        end
        FILL: begin
          hold_s  = HW'({hold_r, conf_in_d});
          cnt_s   = cnt_r + CW'(1);
          state_s = (cnt_r == CW'(last_fill_count(NWORDS))) ? LAST : FILL;
        end
        default: begin
          state_s = FILL;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end else if (timeout_s) begin
      state_s = FILL;
      cnt_s   = {CW{1'b0}};
      err_s   = 1'b1;
    end else begin
      state_s = state_r;
    end
  end

  // Lane state, assembly and output buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FILL;
      cnt_r   <= {CW{1'b0}};
      hold_r  <= {HW{1'b0}};
      out_d_r <= {PW{1'b0}};
      out_v_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      hold_r  <= hold_s;
      out_d_r <= out_d_s;
      out_v_r <= out_v_s;
      err_r   <= err_s;
    end
  end

endmodule

// File: rtl/pc_conf_assembler.sv
// NCHAN independent config-word assembler lanes with per-lane port slicing.
// PC_CONF_ASSEMBLER_TIMEOUT_EN enables the per-lane partial-assembly timeout.
module pc_conf_assembler
  import pc_conf_pkg::*;
#(
  parameter int NCONF   = DEF_NCONF,
  parameter int NCHAN   = DEF_NCHAN,
  parameter int NWORDS  = DEF_NWORDS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NCHAN*NCONF-1:0]            conf_in_d,
  input  logic [NCHAN-1:0]                  conf_in_v,
  output logic [NCHAN-1:0]                  conf_in_a,
  output logic [NCHAN*NCONF*NWORDS-1:0]     prog_out_d,
  output logic [NCHAN-1:0]                  prog_out_v,
  input  logic [NCHAN-1:0]                  prog_out_a,
  output logic [NCHAN*$clog2(NWORDS)-1:0]   words_pending,
  input  logic [NCHAN-1:0]                  flush,
  output logic [NCHAN-1:0]                  err_timeout
);

  localparam int CW = $clog2(NWORDS);
  localparam int PW = NCONF * NWORDS;

  for (genvar i = 0; i < NCHAN; i++) begin : g_lane
    pc_conf_assembler_lane #(
      .NCONF   (NCONF),
      .NWORDS  (NWORDS),
      .TIMEOUT (TIMEOUT)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .conf_in_d     (conf_in_d[i*NCONF +: NCONF]),
      .conf_in_v     (conf_in_v[i]),
      .conf_in_a     (conf_in_a[i]),
      .prog_out_d    (prog_out_d[i*PW +: PW]),
      .prog_out_v    (prog_out_v[i]),
      .prog_out_a    (prog_out_a[i]),
      .words_pending (words_pending[i*CW +: CW]),
      .flush         (flush[i]),
      .err_timeout   (err_timeout[i])
    );
  end

endmodule
